// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, tick / done strobe / received word out.
`timescale 1ns/1ps
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_rx_data;
    logic                  o_tick;
    logic                  o_rx_done_bit;
    logic [DATA_WIDTH-1:0] o_data_byte;
    logic                  o_frame_err;

    modport master (
        input  i_rx_data,
        output o_tick,
        output o_rx_done_bit,
        output o_data_byte,
        output o_frame_err
    );

    modport slave (
        output i_rx_data,
        input  o_tick,
        input  o_rx_done_bit,
        input  o_data_byte,
        input  o_frame_err
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: free-running oversample tick divider, 2-flop input synchroniser and
// start/data/stop FSM producing a parallel word with a single-cycle done strobe.
`timescale 1ns/1ps
module uart_rx_core #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 19200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_WIDTH = 1
) (
    input logic       clk,
    input logic       reset,
    uart_rx_if.master bus
);
    localparam int DIV       = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int STOP_LAST = OVERSAMPLE * STOP_WIDTH - 1;
    localparam int S_W       = (STOP_LAST > 0) ? $clog2(STOP_LAST + 1) : 1;
    localparam int N_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV - 1);
    localparam logic [S_W-1:0]   S_MID       = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0]   S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0]   S_STOP_LAST = S_W'(STOP_LAST);
    localparam logic [N_W-1:0]   N_LAST      = N_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [DIV_W-1:0]      tick_cnt;
    logic                  tick;
    logic                  rx_p0;
    logic                  rx_p1;
    state_t                state;
    logic [S_W-1:0]        s;
    logic [N_W-1:0]        n;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] data_byte;
    logic                  rx_done;
    logic                  frame_err;

    // Tick divider runs continuously and is never re-aligned to the incoming frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick_cnt == DIV_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == DIV_LAST);

    // Synchroniser flops come out of reset high so an idle line never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= bus.i_rx_data;
            rx_p1 <= rx_p0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            shift_reg <= '0;
            data_byte <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_p1) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == S_MID) begin
                            // Start bit must still be low at its centre, otherwise treat it as a glitch.
                            if (!rx_p1) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == S_BIT_LAST) begin
                            shift_reg <= {rx_p1, shift_reg[DATA_WIDTH-1:1]};
                            s         <= '0;
                            if (n == N_LAST) begin
                                state <= STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s == S_STOP_LAST) begin
                            data_byte <= shift_reg;
                            frame_err <= ~rx_p1;
                            rx_done   <= 1'b1;
                            state     <= IDLE;
                            s         <= '0;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_tick        = tick;
    assign bus.o_rx_done_bit = rx_done;
    assign bus.o_data_byte   = data_byte;
    assign bus.o_frame_err   = frame_err;
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed scenarios plus randomized frames at a few percent baud
// mismatch, scored against a queue of expected words built from the sent bytes.
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int CLK_FREQ = 2_000_000;
    localparam int BAUD     = 12_500;
    localparam int OS       = 16;
    localparam int DW       = 8;
    localparam int DIV      = (CLK_FREQ + BAUD * OS / 2) / (BAUD * OS);
    localparam int BIT_CLKS = DIV * OS;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    uart_rx_if #(.DATA_WIDTH(DW)) bus ();
    uart_rx_if #(.DATA_WIDTH(8))  bus_def ();

    uart_rx_core #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_WIDTH(DW), .STOP_WIDTH(1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    uart_rx_core dut_def (
        .clk(clk), .reset(reset), .bus(bus_def)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] last_byte = 8'h00;
    int ticks_in_reset = 0;
    int long_done = 0;
    logic done_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (bus.o_rx_done_bit === 1'b1) got_q.push_back({bus.o_frame_err, bus.o_data_byte});
        if (done_prev && bus.o_rx_done_bit === 1'b1) long_done++;
        done_prev = (bus.o_rx_done_bit === 1'b1);
        if (reset && (bus.o_tick !== 1'b0 || bus_def.o_tick !== 1'b0)) ticks_in_reset++;
    end

    task automatic send_bit(input logic v, input int clks);
        bus.i_rx_data = v;
        repeat (clks) @(negedge clk);
    endtask

    // A bad stop bit is held low for only 3/4 of a bit so the following high level
    // lets the receiver's start check reject the tail instead of framing garbage.
    task automatic send_frame(input logic [7:0] b, input int bclk, input bit stop_ok);
        exp_q.push_back({~stop_ok, b});
        last_byte = b;
        send_bit(1'b0, bclk);
        for (int i = 0; i < 8; i++) send_bit(b[i], bclk);
        if (stop_ok) begin
            send_bit(1'b1, bclk);
        end else begin
            send_bit(1'b0, bclk * 3 / 4);
            send_bit(1'b1, bclk - bclk * 3 / 4);
        end
    endtask

    task automatic drain(input string tag);
        int c;
        logic [8:0] g;
        logic [8:0] e;
        c = 0;
        while (got_q.size() < exp_q.size() && c < 4 * BIT_CLKS) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_word"}, {23'd0, g}, {23'd0, e});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic tick_period(input bit use_def, output int p);
        int c;
        c = 0;
        while (((use_def ? bus_def.o_tick : bus.o_tick) !== 1'b1) && c < 400) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        c = 1;
        while (((use_def ? bus_def.o_tick : bus.o_tick) !== 1'b1) && c < 400) begin
            @(negedge clk);
            c++;
        end
        p = c;
    endtask

    initial begin
        int p;
        logic [7:0] b;
        int bclk;
        int gap;

        reset = 1'b1;
        bus.i_rx_data = 1'b1;
        bus_def.i_rx_data = 1'b1;
        repeat (25) @(negedge clk);
        chk("rst_done", 32'(bus.o_rx_done_bit), 0);
        chk("rst_data", 32'(bus.o_data_byte), 0);
        chk("rst_ferr", 32'(bus.o_frame_err), 0);
        chk("rst_tick", 32'(bus.o_tick), 0);
        reset = 1'b0;

        tick_period(1'b0, p);
        chk("tick_period", p, DIV);
        tick_period(1'b1, p);
        chk("tick_period_default", p, 163);
        repeat (BIT_CLKS) @(negedge clk);

        send_frame(8'h6A, BIT_CLKS, 1'b1);
        drain("frame_6a");
        repeat (BIT_CLKS) @(negedge clk);
        chk("hold_data", 32'(bus.o_data_byte), 32'h6A);
        chk("hold_ferr", 32'(bus.o_frame_err), 0);
        chk("hold_no_done", got_q.size(), 0);

        send_frame(8'h00, BIT_CLKS, 1'b1);
        send_frame(8'hFF, BIT_CLKS, 1'b1);
        send_frame(8'h55, BIT_CLKS, 1'b1);
        drain("b2b");

        send_bit(1'b0, BIT_CLKS * 3 / 10);
        send_bit(1'b1, 2 * BIT_CLKS);
        chk("glitch_no_done", got_q.size(), 0);
        chk("glitch_data", 32'(bus.o_data_byte), 32'(last_byte));

        send_frame(8'hA5, BIT_CLKS, 1'b0);
        drain("frame_err");
        chk("ferr_flag", 32'(bus.o_frame_err), 1);
        send_bit(1'b1, 12 * BIT_CLKS);
        chk("ferr_no_spurious", got_q.size(), 0);

        b = 8'hC3;
        send_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) send_bit(b[i], BIT_CLKS);
        send_bit(b[4], BIT_CLKS / 2);
        reset = 1'b1;
        bus.i_rx_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_data", 32'(bus.o_data_byte), 0);
        chk("midrst_done", 32'(bus.o_rx_done_bit), 0);
        reset = 1'b0;
        send_bit(1'b1, 12 * BIT_CLKS);
        chk("midrst_no_done", got_q.size(), 0);
        send_frame(8'h3C, BIT_CLKS, 1'b1);
        drain("after_rst");
        chk("after_rst_data", 32'(bus.o_data_byte), 32'h3C);

        for (int k = 0; k < 20; k++) begin
            b = 8'($urandom);
            bclk = $urandom_range(BIT_CLKS * 97 / 100, BIT_CLKS * 103 / 100);
            gap = $urandom_range(0, BIT_CLKS);
            send_frame(b, bclk, 1'b1);
            if (gap > 0) send_bit(1'b1, gap);
        end
        drain("random");
        chk("random_last_data", 32'(bus.o_data_byte), 32'(last_byte));

        chk("tick_during_reset", ticks_in_reset, 0);
        chk("done_single_cycle", long_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
